// File: rtl/router_ctrl_fsm_pkg.sv
// rtl/router_ctrl_fsm_pkg.sv - shared router types: port/address sizing, FSM state enum, control-output bundle
package router_ctrl_fsm_pkg;

  localparam int NUM_PORTS = 3;
  localparam int ADDR_W    = 2;
  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'd3;

  typedef enum logic [7:0] {
    DECODE_ADDRESS     = 8'b0000_0001,
    LOAD_FIRST_DATA    = 8'b0000_0010,
    LOAD_DATA          = 8'b0000_0100,
    FIFO_FULL_STATE    = 8'b0000_1000,
    LOAD_AFTER_FULL    = 8'b0001_0000,
    LOAD_PARITY        = 8'b0010_0000,
    CHECK_PARITY_ERROR = 8'b0100_0000,
    WAIT_TILL_EMPTY    = 8'b1000_0000
  } state_t;

  typedef struct packed {
    logic detect_add;
    logic lfd_state;
    logic ld_state;
    logic laf_state;
    logic full_state;
    logic write_enb_reg;
    logic rst_int_reg;
    logic busy;
  } ctrl_out_t;

  // Moore output decode; registered by the FSM alongside the state it describes.
  function automatic ctrl_out_t decode_outputs(input state_t s);
    ctrl_out_t o;
    o = '0;
    case (s)
      DECODE_ADDRESS: begin
        o.detect_add = 1'b1;
      end
      LOAD_FIRST_DATA: begin
        o.lfd_state = 1'b1;
        o.busy      = 1'b1;
      end
      LOAD_DATA: begin
        o.ld_state      = 1'b1;
        o.write_enb_reg = 1'b1;
      end
      FIFO_FULL_STATE: begin
        o.full_state = 1'b1;
        o.busy       = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        o.laf_state     = 1'b1;
        o.write_enb_reg = 1'b1;
        o.busy          = 1'b1;
      end
      LOAD_PARITY: begin
        o.write_enb_reg = 1'b1;
        o.busy          = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        o.rst_int_reg = 1'b1;
        o.busy        = 1'b1;
      end
      WAIT_TILL_EMPTY: begin
        o.busy = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/router_ctrl_fsm.sv
// rtl/router_ctrl_fsm.sv - 1x3 router ingress FSM: header decode, payload/parity sequencing, full stall
module router_ctrl_fsm
  import router_ctrl_fsm_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic [ADDR_W-1:0]    dest_sel,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 write_enb_reg,
  output logic                 rst_int_reg,
  output logic                 busy
);

  // Per-port flags are widened to the full address space so any address indexes safely.
  localparam int SLOTS = 1 << ADDR_W;

  state_t           state;
  state_t           nxt;
  ctrl_out_t        outs;
  logic [SLOTS-1:0] empty_ext;
  logic [SLOTS-1:0] soft_ext;
  logic             addr_ok;
  logic             hdr_take;
  logic             soft_hit;

  assign empty_ext = SLOTS'(fifo_empty);
  assign soft_ext  = SLOTS'(soft_reset);
  assign addr_ok   = ({1'b0, data_in} < (ADDR_W + 1)'(NUM_PORTS));
  assign hdr_take  = pkt_valid && addr_ok;
  assign soft_hit  = soft_ext[dest_sel];

  always_comb begin
    nxt = DECODE_ADDRESS;
    if (state != DECODE_ADDRESS && soft_hit) begin
      nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (!hdr_take)                nxt = DECODE_ADDRESS;
          else if (empty_ext[data_in])  nxt = LOAD_FIRST_DATA;
          else                          nxt = WAIT_TILL_EMPTY;
        end
        LOAD_FIRST_DATA: nxt = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       nxt = FIFO_FULL_STATE;
          else if (!pkt_valid) nxt = LOAD_PARITY;
          else                 nxt = LOAD_DATA;
        end
        FIFO_FULL_STATE: nxt = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
        LOAD_AFTER_FULL: begin
          if (parity_done)        nxt = DECODE_ADDRESS;
          else if (low_pkt_valid) nxt = LOAD_PARITY;
          else                    nxt = LOAD_DATA;
        end
        LOAD_PARITY:        nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:    nxt = empty_ext[dest_sel] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        default:            nxt = DECODE_ADDRESS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= DECODE_ADDRESS;
      dest_sel <= '0;
      outs     <= decode_outputs(DECODE_ADDRESS);
    end else begin
      state <= nxt;
      outs  <= decode_outputs(nxt);
      if (state == DECODE_ADDRESS && hdr_take) begin
        dest_sel <= data_in;
      end
    end
  end

  assign detect_add    = outs.detect_add;
  assign lfd_state     = outs.lfd_state;
  assign ld_state      = outs.ld_state;
  assign laf_state     = outs.laf_state;
  assign full_state    = outs.full_state;
  assign write_enb_reg = outs.write_enb_reg;
  assign rst_int_reg   = outs.rst_int_reg;
  assign busy          = outs.busy;

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// tb/tb_router_ctrl_fsm.sv - scoreboard bench for router_ctrl_fsm: directed packet scenarios plus random traffic
module tb_router_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_empty;
  logic       fifo_full;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_pkt_valid;
  logic [1:0] dest_sel;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  router_ctrl_fsm dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .dest_sel(dest_sel),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {M_DEC, M_LFD, M_LD, M_FULL, M_LAF, M_LP, M_CPE, M_WTE} mstate_t;

  mstate_t    m_st;
  int         m_dsel;
  logic [9:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc_no = 0;

  // Expected outputs in the form {dest_sel, detect, lfd, ld, laf, full, wen, rst_int, busy}.
  function automatic logic [9:0] model_out();
    logic [9:0] v;
    v[9:8] = 2'(m_dsel);
    v[7]   = (m_st == M_DEC);
    v[6]   = (m_st == M_LFD);
    v[5]   = (m_st == M_LD);
    v[4]   = (m_st == M_LAF);
    v[3]   = (m_st == M_FULL);
    v[2]   = (m_st inside {M_LD, M_LP, M_LAF});
    v[1]   = (m_st == M_CPE);
    v[0]   = !(m_st inside {M_DEC, M_LD});
    return v;
  endfunction

  task automatic model_step();
    int a;
    a = int'(data_in);
    if (reset) begin
      m_st = M_DEC; m_dsel = 0;
    end else if (m_st != M_DEC && soft_reset[m_dsel]) begin
      m_st = M_DEC;
    end else begin
      case (m_st)
        M_DEC: if (pkt_valid && a < 3) begin
          m_dsel = a;
          m_st = fifo_empty[a] ? M_LFD : M_WTE;
        end
        M_LFD:  m_st = M_LD;
        M_LD:   m_st = fifo_full ? M_FULL : (!pkt_valid ? M_LP : M_LD);
        M_FULL: m_st = fifo_full ? M_FULL : M_LAF;
        M_LAF:  m_st = parity_done ? M_DEC : (low_pkt_valid ? M_LP : M_LD);
        M_LP:   m_st = M_CPE;
        M_CPE:  m_st = fifo_full ? M_FULL : M_DEC;
        M_WTE:  m_st = fifo_empty[m_dsel] ? M_LFD : M_WTE;
        default: m_st = M_DEC;
      endcase
    end
  endtask

  task automatic cyc(input logic r, input logic pv, input logic [1:0] din,
                     input logic [2:0] emp, input logic fl, input logic [2:0] sr,
                     input logic pd, input logic lpv);
    reset = r; pkt_valid = pv; data_in = din; fifo_empty = emp;
    fifo_full = fl; soft_reset = sr; parity_done = pd; low_pkt_valid = lpv;
    model_step();
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] e, act;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {dest_sel, detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy};
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL outputs cycle %0d: got %b required %b (dsel,det,lfd,ld,laf,full,wen,rst,busy)",
                   cyc_no, act, e);
        end
      end
    end
  end

  initial begin
    m_st = M_DEC; m_dsel = 0;
    cyc(1, 0, 0, 3'b111, 0, 0, 0, 0);
    cyc(1, 0, 0, 3'b111, 0, 0, 0, 0);
    cyc(0, 0, 0, 3'b111, 0, 0, 0, 0);
    // Full packet to port 1
    cyc(0, 1, 1, 3'b111, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 3'b111, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 3'b111, 0, 0, 0, 0);
    // Invalid address is dropped
    for (int i = 0; i < 3; i++) cyc(0, 1, 3, 3'b111, 0, 0, 0, 0);
    // Wait for port 2 to drain
    cyc(0, 1, 2, 3'b011, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 3'b011, 0, 0, 0, 0);
    cyc(0, 1, 0, 3'b111, 0, 0, 0, 0);
    cyc(0, 1, 0, 3'b111, 0, 0, 0, 0);
    // Full stall and recovery
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 3'b111, 1, 0, 0, 0);
    cyc(0, 1, 0, 3'b111, 0, 0, 0, 0);
    cyc(0, 1, 0, 3'b111, 0, 0, 0, 0);
    cyc(0, 1, 0, 3'b111, 0, 0, 0, 0);
    // Soft reset: selected port aborts, others ignored
    cyc(0, 1, 0, 3'b111, 0, 3'b100, 0, 0);
    cyc(0, 1, 0, 3'b111, 0, 0, 0, 0);
    cyc(0, 1, 0, 3'b111, 0, 0, 0, 0);
    cyc(0, 1, 0, 3'b111, 0, 0, 0, 0);
    cyc(0, 1, 0, 3'b111, 0, 3'b010, 0, 0);
    cyc(0, 1, 0, 3'b111, 0, 3'b001, 0, 0);
    cyc(0, 0, 0, 3'b111, 0, 0, 0, 0);
    // Hard reset while stalled on full
    cyc(0, 1, 2, 3'b111, 0, 0, 0, 0);
    cyc(0, 1, 0, 3'b111, 0, 0, 0, 0);
    cyc(0, 1, 0, 3'b111, 1, 0, 0, 0);
    cyc(0, 1, 0, 3'b111, 1, 0, 0, 0);
    cyc(1, 1, 0, 3'b111, 1, 0, 0, 0);
    cyc(0, 0, 0, 3'b111, 0, 0, 0, 0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] sr;
      sr[0] = ($urandom_range(0, 31) == 0);
      sr[1] = ($urandom_range(0, 31) == 0);
      sr[2] = ($urandom_range(0, 31) == 0);
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
          3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), sr,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
